// File: rtl/opl3_stereo_mixer.sv
// OPL3 stereo output stage: sample-rate divider plus a serial per-channel mixer with
// pan, shift attenuation, saturation, sticky status flags and a valid/ready output.
module opl3_stereo_mixer #(
    parameter int SAMPLE_WIDTH  = 16,
    parameter int NUM_CH        = 4,
    parameter int CLK_DIV_COUNT = 256,
    parameter int ATT_WIDTH     = 3
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic [NUM_CH-1:0][SAMPLE_WIDTH-1:0]  ch_sample_i,
    input  logic [NUM_CH-1:0]                    ch_pan_l_i,
    input  logic [NUM_CH-1:0]                    ch_pan_r_i,
    input  logic [NUM_CH-1:0][ATT_WIDTH-1:0]     ch_att_i,
    input  logic                                 clear_flags_i,
    output logic                                 sample_clk_en_o,
    output logic signed [SAMPLE_WIDTH-1:0]       sample_l_o,
    output logic signed [SAMPLE_WIDTH-1:0]       sample_r_o,
    output logic                                 sample_valid_o,
    input  logic                                 sample_ready_i,
    output logic                                 clip_l_o,
    output logic                                 clip_r_o,
    output logic                                 overrun_o
);

    localparam int AW = SAMPLE_WIDTH + $clog2(NUM_CH) + 1;
    localparam int CW = $clog2(CLK_DIV_COUNT);
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV_COUNT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_CH - 1);

    localparam logic signed [AW-1:0] ACC_MAX =
        {{(AW-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN =
        {{(AW-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};
    localparam logic signed [SAMPLE_WIDTH-1:0] OUT_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [SAMPLE_WIDTH-1:0] OUT_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_SAT,
        S_OUT
    } state_t;

    state_t                                state_q, state_d;
    logic [CW-1:0]                         cnt_q, cnt_d;
    logic                                  en_q, en_d;
    logic [IW-1:0]                         idx_q, idx_d;
    logic [NUM_CH-1:0][SAMPLE_WIDTH-1:0]   snap_sample_q, snap_sample_d;
    logic [NUM_CH-1:0]                     snap_pan_l_q, snap_pan_l_d;
    logic [NUM_CH-1:0]                     snap_pan_r_q, snap_pan_r_d;
    logic [NUM_CH-1:0][ATT_WIDTH-1:0]      snap_att_q, snap_att_d;
    logic signed [AW-1:0]                  acc_l_q, acc_l_d;
    logic signed [AW-1:0]                  acc_r_q, acc_r_d;
    logic signed [SAMPLE_WIDTH-1:0]        out_l_q, out_l_d;
    logic signed [SAMPLE_WIDTH-1:0]        out_r_q, out_r_d;
    logic                                  clip_l_q, clip_l_d;
    logic                                  clip_r_q, clip_r_d;
    logic                                  overrun_q, overrun_d;

    logic signed [SAMPLE_WIDTH-1:0]        sel_sample;
    logic signed [AW-1:0]                  sel_ext;
    logic signed [AW-1:0]                  term;
    logic signed [SAMPLE_WIDTH-1:0]        sat_l, sat_r;
    logic                                  sat_hit_l, sat_hit_r;
    logic                                  take_snap;
    logic                                  set_clip_l, set_clip_r, set_overrun;

    // The enable register tracks the next counter value so it is high exactly while the counter sits at its last count.
    always_comb begin
        cnt_d = (cnt_q == DIV_LAST) ? '0 : cnt_q + CW'(1);
        en_d  = (cnt_d == DIV_LAST);
    end

    always_comb begin
        sel_sample = snap_sample_q[idx_q];
        sel_ext    = {{(AW-SAMPLE_WIDTH){sel_sample[SAMPLE_WIDTH-1]}}, sel_sample};
        term       = sel_ext >>> snap_att_q[idx_q];
    end

    always_comb begin
        sat_l     = acc_l_q[SAMPLE_WIDTH-1:0];
        sat_hit_l = 1'b0;
        if (acc_l_q > ACC_MAX) begin
            sat_l     = OUT_MAX;
            sat_hit_l = 1'b1;
        end else if (acc_l_q < ACC_MIN) begin
            sat_l     = OUT_MIN;
            sat_hit_l = 1'b1;
        end
        sat_r     = acc_r_q[SAMPLE_WIDTH-1:0];
        sat_hit_r = 1'b0;
        if (acc_r_q > ACC_MAX) begin
            sat_r     = OUT_MAX;
            sat_hit_r = 1'b1;
        end else if (acc_r_q < ACC_MIN) begin
            sat_r     = OUT_MIN;
            sat_hit_r = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        snap_sample_d = snap_sample_q;
        snap_pan_l_d  = snap_pan_l_q;
        snap_pan_r_d  = snap_pan_r_q;
        snap_att_d    = snap_att_q;
        acc_l_d       = acc_l_q;
        acc_r_d       = acc_r_q;
        out_l_d       = out_l_q;
        out_r_d       = out_r_q;
        take_snap     = 1'b0;
        set_clip_l    = 1'b0;
        set_clip_r    = 1'b0;
        set_overrun   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en_q) begin
                    take_snap = 1'b1;
                end
            end
            S_ACCUM: begin
                if (snap_pan_l_q[idx_q]) begin
                    acc_l_d = acc_l_q + term;
                end
                if (snap_pan_r_q[idx_q]) begin
                    acc_r_d = acc_r_q + term;
                end
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = S_SAT;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_SAT: begin
                out_l_d    = sat_l;
                out_r_d    = sat_r;
                set_clip_l = sat_hit_l;
                set_clip_r = sat_hit_r;
                state_d    = S_OUT;
            end
            S_OUT: begin
                // A frame tick that coincides with acceptance starts the next frame without loss.
                if (sample_ready_i) begin
                    state_d = S_IDLE;
                    if (en_q) begin
                        take_snap = 1'b1;
                    end
                end else if (en_q) begin
                    set_overrun = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (take_snap) begin
            snap_sample_d = ch_sample_i;
            snap_pan_l_d  = ch_pan_l_i;
            snap_pan_r_d  = ch_pan_r_i;
            snap_att_d    = ch_att_i;
            acc_l_d       = '0;
            acc_r_d       = '0;
            idx_d         = '0;
            state_d       = S_ACCUM;
        end
    end

    always_comb begin
        clip_l_d  = set_clip_l  | (clip_l_q  & ~clear_flags_i);
        clip_r_d  = set_clip_r  | (clip_r_q  & ~clear_flags_i);
        overrun_d = set_overrun | (overrun_q & ~clear_flags_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            en_q          <= 1'b0;
            idx_q         <= '0;
            snap_sample_q <= '0;
            snap_pan_l_q  <= '0;
            snap_pan_r_q  <= '0;
            snap_att_q    <= '0;
            acc_l_q       <= '0;
            acc_r_q       <= '0;
            out_l_q       <= '0;
            out_r_q       <= '0;
            clip_l_q      <= 1'b0;
            clip_r_q      <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            en_q          <= en_d;
            idx_q         <= idx_d;
            snap_sample_q <= snap_sample_d;
            snap_pan_l_q  <= snap_pan_l_d;
            snap_pan_r_q  <= snap_pan_r_d;
            snap_att_q    <= snap_att_d;
            acc_l_q       <= acc_l_d;
            acc_r_q       <= acc_r_d;
            out_l_q       <= out_l_d;
            out_r_q       <= out_r_d;
            clip_l_q      <= clip_l_d;
            clip_r_q      <= clip_r_d;
            overrun_q     <= overrun_d;
        end
    end

    assign sample_clk_en_o = en_q;
    assign sample_l_o      = out_l_q;
    assign sample_r_o      = out_r_q;
    assign sample_valid_o  = (state_q == S_OUT);
    assign clip_l_o        = clip_l_q;
    assign clip_r_o        = clip_r_q;
    assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_opl3_stereo_mixer.sv
// Bench for opl3_stereo_mixer: frame-level mixing model checked every cycle, plus
// directed scenarios with hand-computed literal results.
module tb_opl3_stereo_mixer;

    localparam int SW  = 16;
    localparam int NCH = 4;
    localparam int DIV = 256;
    localparam int ATW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                          rstN;
    logic [NCH-1:0][SW-1:0]        chSample;
    logic [NCH-1:0]                panL;
    logic [NCH-1:0]                panR;
    logic [NCH-1:0][ATW-1:0]       chAtt;
    logic                          clearFlags;
    logic                          ready;
    logic                          sampleClkEn;
    logic signed [SW-1:0]          sampleL;
    logic signed [SW-1:0]          sampleR;
    logic                          sampleValid;
    logic                          clipL;
    logic                          clipR;
    logic                          overrun;

    int compared   = 0;
    int mismatched = 0;

    opl3_stereo_mixer #(
        .SAMPLE_WIDTH  (SW),
        .NUM_CH        (NCH),
        .CLK_DIV_COUNT (DIV),
        .ATT_WIDTH     (ATW)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rstN),
        .ch_sample_i     (chSample),
        .ch_pan_l_i      (panL),
        .ch_pan_r_i      (panR),
        .ch_att_i        (chAtt),
        .clear_flags_i   (clearFlags),
        .sample_clk_en_o (sampleClkEn),
        .sample_l_o      (sampleL),
        .sample_r_o      (sampleR),
        .sample_valid_o  (sampleValid),
        .sample_ready_i  (ready),
        .clip_l_o        (clipL),
        .clip_r_o        (clipR),
        .overrun_o       (overrun)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int s0, input int s1, input int s2, input int s3,
                                 input int att, input logic [NCH-1:0] pl, input logic [NCH-1:0] pr);
        chSample[0] = SW'(s0);
        chSample[1] = SW'(s1);
        chSample[2] = SW'(s2);
        chSample[3] = SW'(s3);
        for (int i = 0; i < NCH; i++) chAtt[i] = ATW'(att);
        panL = pl;
        panR = pr;
    endtask

    // Frame-level model: a tick starts a mix of the inputs present at that tick; the clamped
    // result appears NUM_CH+2 cycles later and is held until accepted.
    bit modelLive = 0;
    int cyc, pend;
    int expL, expR, resL, resR;
    bit expValid, expClipL, expClipR, expOverrun, resClipL, resClipR;

    function automatic int sideSum(input logic [NCH-1:0] pan);
        int s = 0;
        for (int i = 0; i < NCH; i++)
            if (pan[i]) s += int'($signed(chSample[i])) >>> chAtt[i];
        return s;
    endfunction

    function automatic int clampS(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic modelStart();
        int l, r;
        l = sideSum(panL);
        r = sideSum(panR);
        resL = clampS(l);
        resR = clampS(r);
        resClipL = (resL != l);
        resClipR = (resR != r);
        pend = NCH + 1;
    endtask

    always @(posedge clk) begin
        if (!rstN) begin
            modelLive  = 1;
            cyc        = 1;
            pend       = 0;
            expL       = 0;
            expR       = 0;
            expValid   = 0;
            expClipL   = 0;
            expClipR   = 0;
            expOverrun = 0;
        end else if (modelLive) begin
            bit en, setL, setR, setOv, nextValid;
            en = (cyc % DIV == 0);
            setL = 0; setR = 0; setOv = 0;
            nextValid = expValid;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    expL = resL;
                    expR = resR;
                    setL = resClipL;
                    setR = resClipR;
                    nextValid = 1;
                end
            end else if (expValid) begin
                if (ready) begin
                    nextValid = 0;
                    if (en) modelStart();
                end else if (en) begin
                    setOv = 1;
                end
            end else if (en) begin
                modelStart();
            end
            expClipL   = setL  | (expClipL   & !clearFlags);
            expClipR   = setR  | (expClipR   & !clearFlags);
            expOverrun = setOv | (expOverrun & !clearFlags);
            expValid   = nextValid;
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("sample_clk_en", int'(sampleClkEn), int'(cyc % DIV == 0));
            checkOutput("sample_valid", int'(sampleValid), int'(expValid));
            checkOutput("sample_l", int'(sampleL), expL);
            checkOutput("sample_r", int'(sampleR), expR);
            checkOutput("clip_l", int'(clipL), int'(expClipL));
            checkOutput("clip_r", int'(clipR), int'(expClipR));
            checkOutput("overrun", int'(overrun), int'(expOverrun));
        end
    end

    task automatic waitEnable();
        int n = 0;
        @(negedge clk);
        while (!sampleClkEn && n < 2 * DIV) begin
            @(negedge clk);
            n++;
        end
        if (!sampleClkEn) checkOutput("enableTimeout", 0, 1);
    endtask

    task automatic waitValid(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!sampleValid && k < 20);
    endtask

    task automatic countToEnable(output int c);
        c = 1;
        while (!sampleClkEn && c < 2 * DIV) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        int k, c;
        rstN = 0;
        clearFlags = 0;
        ready = 1;
        applyStimulus(0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstN = 1;

        $display("[TB] reset state and divider");
        checkOutput("rstValid", int'(sampleValid), 0);
        checkOutput("rstL", int'(sampleL), 0);
        checkOutput("rstR", int'(sampleR), 0);
        checkOutput("rstEn", int'(sampleClkEn), 0);
        applyStimulus(1000, 2000, 3000, -4000, 1, 4'b0101, 4'b1010);
        countToEnable(c);
        checkOutput("firstEnCycle", c, 256);

        $display("[TB] basic mix with attenuation");
        waitValid(k);
        checkOutput("mixLatency", k, 6);
        checkOutput("mixL", int'(sampleL), 2000);
        checkOutput("mixR", int'(sampleR), -1000);
        @(negedge clk);
        checkOutput("validOneCycle", int'(sampleValid), 0);
        checkOutput("holdL", int'(sampleL), 2000);

        $display("[TB] positive and negative saturation");
        applyStimulus(32767, 32767, 32767, 32767, 0, 4'b1111, 4'b1111);
        waitEnable();
        waitValid(k);
        checkOutput("satPosL", int'(sampleL), 32767);
        checkOutput("satPosR", int'(sampleR), 32767);
        checkOutput("clipL", int'(clipL), 1);
        checkOutput("clipR", int'(clipR), 1);
        applyStimulus(-32768, -32768, -32768, -32768, 0, 4'b1111, 4'b1111);
        waitEnable();
        waitValid(k);
        checkOutput("satNegL", int'(sampleL), -32768);
        checkOutput("satNegR", int'(sampleR), -32768);
        clearFlags = 1;
        @(negedge clk);
        clearFlags = 0;
        checkOutput("clearClipL", int'(clipL), 0);
        checkOutput("clearClipR", int'(clipR), 0);

        $display("[TB] backpressure overrun");
        ready = 0;
        applyStimulus(100, 200, 300, 400, 0, 4'b0101, 4'b1010);
        waitEnable();
        waitValid(k);
        checkOutput("bpL", int'(sampleL), 400);
        checkOutput("bpR", int'(sampleR), 600);
        applyStimulus(5000, 5000, 5000, 5000, 2, 4'b1111, 4'b0001);
        waitEnable();
        @(negedge clk);
        checkOutput("overrunSet", int'(overrun), 1);
        checkOutput("overrunValidHeld", int'(sampleValid), 1);
        checkOutput("overrunKeepL", int'(sampleL), 400);
        checkOutput("overrunKeepR", int'(sampleR), 600);
        ready = 1;
        @(negedge clk);
        checkOutput("acceptedValid", int'(sampleValid), 0);

        $display("[TB] accept coinciding with frame tick");
        clearFlags = 1;
        @(negedge clk);
        clearFlags = 0;
        ready = 0;
        waitEnable();
        waitValid(k);
        checkOutput("coL", int'(sampleL), 5000);
        checkOutput("coR", int'(sampleR), 1250);
        waitEnable();
        checkOutput("coValidAtTick", int'(sampleValid), 1);
        ready = 1;
        waitValid(k);
        checkOutput("coLatency", k, 6);
        checkOutput("coNoOverrun", int'(overrun), 0);

        $display("[TB] reset during accumulation");
        waitEnable();
        @(negedge clk);
        rstN = 0;
        @(negedge clk);
        rstN = 1;
        checkOutput("midRstValid", int'(sampleValid), 0);
        checkOutput("midRstL", int'(sampleL), 0);
        checkOutput("midRstR", int'(sampleR), 0);
        applyStimulus(1000, 2000, 3000, -4000, 1, 4'b0101, 4'b1010);
        countToEnable(c);
        checkOutput("midRstEnCycle", c, 256);
        waitValid(k);
        checkOutput("midRstLatency", k, 6);
        checkOutput("midRstMixL", int'(sampleL), 2000);
        checkOutput("midRstMixR", int'(sampleR), -1000);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
